// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dbg_pkg
//  Description : Shared definitions for the MIPS run/step/debug sequencer:
//                host command opcodes, sequencer state encoding and the
//                number of general purpose registers streamed by DUMP.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_dbg_pkg;

    // Host command opcodes; 5..7 are illegal.
    localparam logic [2:0] OP_RUN   = 3'd0;
    localparam logic [2:0] OP_STEP  = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_DUMP  = 3'd4;

    localparam int NREGS = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DUMP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl_if
//  Description : Bundle of host-command, core-control and GPR-dump signals
//                around the run controller.
//                  slave  : the run controller itself
//                  master : host / core / dump-sink side
//                Breakpoint signals exist only when MIPS_BREAKPOINT_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_run_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) ();
    // host command channel
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [2:0]       cmd_op_i;
    logic [CNT_W-1:0] cmd_count_i;
    logic             cmd_err_o;
    // core control
    logic [31:0]      pc_i;
    logic             pc_run_en_o;
    logic             pc_clr_o;
    logic [4:0]       ra_debug_o;
    logic [31:0]      ra_debug_data_i;
    // GPR dump stream
    logic             dump_valid_o;
    logic             dump_ready_i;
    logic [4:0]       dump_idx_o;
    logic [31:0]      dump_data_o;
    // status
    logic             halted_o;
    logic [CYC_W-1:0] cycles_o;
`ifdef MIPS_BREAKPOINT_EN
    logic [31:0]      bp_addr_i;
    logic             bp_en_i;
    logic             bp_hit_o;
`endif

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_count_i, pc_i, ra_debug_data_i, dump_ready_i,
`ifdef MIPS_BREAKPOINT_EN
        input  bp_addr_i, bp_en_i,
        output bp_hit_o,
`endif
        output cmd_ready_o, cmd_err_o, pc_run_en_o, pc_clr_o, ra_debug_o,
               dump_valid_o, dump_idx_o, dump_data_o, halted_o, cycles_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_count_i, pc_i, ra_debug_data_i, dump_ready_i,
`ifdef MIPS_BREAKPOINT_EN
        output bp_addr_i, bp_en_i,
        input  bp_hit_o,
`endif
        input  cmd_ready_o, cmd_err_o, pc_run_en_o, pc_clr_o, ra_debug_o,
               dump_valid_o, dump_idx_o, dump_data_o, halted_o, cycles_o
    );
endinterface
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_run_ctrl
//  Description : Run/step/debug sequencer for the single-cycle MIPS core.
//                Executes host commands RUN, STEP n, HALT, CLEAR and DUMP,
//                drives the core's run-enable / pc-clear, and streams all 32
//                GPRs out through the core's debug read port.
//  Ports       : clk_i  - core clock
//                rst_i  - asynchronous reset, active-high
//                bus    - mips_run_ctrl_if.slave (command, core, dump, status)
//  Config      : MIPS_BREAKPOINT_EN - adds PC breakpoint (bp_addr_i, bp_en_i,
//                bp_hit_o); undefined, RUN stops only on HALT.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    mips_run_ctrl_if.slave  bus
);

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_step_cnt, w_step_nxt;
    logic [4:0]       r_idx,      w_idx_nxt;
    logic [CYC_W-1:0] r_cycles;
    logic             r_cmd_err,  w_cmd_err_nxt;

    logic w_ready;
    logic w_accept;
    logic w_run_en;
    logic w_clr;
    logic w_dump_valid;

`ifdef MIPS_BREAKPOINT_EN
    logic r_bp_hit, w_bp_hit_nxt;
    logic r_first,  w_first_nxt;   // first execute cycle after RUN/STEP acceptance
    logic w_bp_match;
`endif

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept = bus.cmd_valid_i && w_ready;

`ifdef MIPS_BREAKPOINT_EN
    // Match is masked on the first cycle so a resume from the breakpoint
    // address executes that instruction instead of stopping again.
    assign w_bp_match = bus.bp_en_i && (bus.pc_i == bus.bp_addr_i) && !r_first &&
                        ((r_state == ST_RUN) || (r_state == ST_STEP));
`endif

    // ------------------------------------------------------------------
    // next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step_cnt;
        w_idx_nxt     = r_idx;
        w_cmd_err_nxt = 1'b0;
        w_run_en      = 1'b0;
        w_clr         = 1'b0;
        w_dump_valid  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op_i)
                        OP_RUN:   w_state_nxt = ST_RUN;
                        OP_STEP: begin
                            w_state_nxt = ST_STEP;
                            w_step_nxt  = (bus.cmd_count_i == '0) ? CNT_W'(1) : bus.cmd_count_i;
                        end
                        OP_HALT:  w_state_nxt = ST_IDLE;
                        OP_CLEAR: w_state_nxt = ST_CLEAR;
                        OP_DUMP: begin
                            w_state_nxt = ST_DUMP;
                            w_idx_nxt   = 5'd0;
                        end
                        default:  w_cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                // the HALT acceptance cycle still executes
                w_run_en = 1'b1;
                if (w_accept) begin
                    if (bus.cmd_op_i == OP_HALT) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                // step count is always >= 1 while in STEP
                w_run_en   = 1'b1;
                w_step_nxt = r_step_cnt - CNT_W'(1);
                if (r_step_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_clr       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_DUMP: begin
                w_dump_valid = 1'b1;
                if (bus.dump_ready_i) begin
                    w_idx_nxt = r_idx + 5'd1;
                    if (r_idx == 5'(NREGS - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef MIPS_BREAKPOINT_EN
        w_first_nxt  = w_accept && (r_state == ST_IDLE) &&
                       ((bus.cmd_op_i == OP_RUN) || (bus.cmd_op_i == OP_STEP));
        w_bp_hit_nxt = w_accept ? 1'b0 : r_bp_hit;
        if (w_bp_match) begin
            // instruction at the breakpoint is not executed; a simultaneous
            // HALT still ends in IDLE with the flag set
            w_run_en     = 1'b0;
            w_state_nxt  = ST_IDLE;
            w_bp_hit_nxt = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_idx      <= 5'd0;
            r_cycles   <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_nxt;
            r_idx      <= w_idx_nxt;
            r_cmd_err  <= w_cmd_err_nxt;
            // clear and run-enable are mutually exclusive by state
            if (w_clr) begin
                r_cycles <= '0;
            end else if (w_run_en) begin
                r_cycles <= r_cycles + CYC_W'(1);
            end
        end
    end

`ifdef MIPS_BREAKPOINT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bp_hit <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_bp_hit <= w_bp_hit_nxt;
            r_first  <= w_first_nxt;
        end
    end
    assign bus.bp_hit_o = r_bp_hit;
`endif

    assign bus.cmd_ready_o  = w_ready;
    assign bus.cmd_err_o    = r_cmd_err;
    assign bus.pc_run_en_o  = w_run_en;
    assign bus.pc_clr_o     = w_clr;
    assign bus.ra_debug_o   = r_idx;
    assign bus.dump_valid_o = w_dump_valid;
    assign bus.dump_idx_o   = r_idx;
    assign bus.dump_data_o  = bus.ra_debug_data_i;
    assign bus.halted_o     = (r_state == ST_IDLE);
    assign bus.cycles_o     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_run_ctrl
//  Description : Self-checking bench for mips_run_ctrl with a tiny core model
//                (pc register + register file) and a command-level model of
//                the controller compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_run_ctrl;
    import mips_dbg_pkg::*;

    localparam int CNT_W = 16;
    localparam int CYC_W = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    mips_run_ctrl_if #(.CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();

    mips_run_ctrl #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- tiny core: pc register and register file ----------
    logic [31:0] core_pc;
    logic [31:0] regs [32];
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                core_pc <= 32'd0;
        else if (bus.pc_clr_o)    core_pc <= 32'd0;
        else if (bus.pc_run_en_o) core_pc <= core_pc + 32'd4;
    end
    assign bus.pc_i            = core_pc;
    assign bus.ra_debug_data_i = regs[bus.ra_debug_o];

    // ---------------- command-level model ------------------------------
    bit          m_run, m_clr, m_dump, m_err, m_bp_hit, m_first;
    int          m_steps, m_idx;
    logic [31:0] m_cycles, m_pc;

    function automatic bit m_idle();
        return !m_run && (m_steps == 0) && !m_clr && !m_dump;
    endfunction
    function automatic bit m_bpm();
`ifdef MIPS_BREAKPOINT_EN
        return bus.bp_en_i && (m_pc == bus.bp_addr_i) && !m_first && (m_run || m_steps > 0);
`else
        return 1'b0;
`endif
    endfunction
    function automatic bit m_run_en();
        return (m_run || m_steps > 0) && !m_bpm();
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        bit idle, en, bpm, acc;
        logic [2:0] op;
        if (rst_i) begin
            m_run = 0; m_clr = 0; m_dump = 0; m_err = 0; m_bp_hit = 0; m_first = 0;
            m_steps = 0; m_idx = 0; m_cycles = 0; m_pc = 0;
        end else begin
            idle = m_idle();
            bpm  = m_bpm();
            en   = m_run_en();
            acc  = bus.cmd_valid_i && (idle || m_run);
            op   = bus.cmd_op_i;
            m_err = acc && ((op > 3'd4) || (m_run && op != OP_HALT));
            if (en) begin m_cycles = m_cycles + 1; m_pc = m_pc + 4; end
            if (m_clr) begin m_cycles = 0; m_pc = 0; m_clr = 0; end
            if (m_steps > 0) m_steps--;
            if (m_dump && bus.dump_ready_i) begin
                if (m_idx == 31) m_dump = 0;
                m_idx = (m_idx + 1) % 32;
            end
            m_first = 0;
            if (acc) begin
                m_bp_hit = 0;
                if (m_run) begin
                    if (op == OP_HALT) m_run = 0;
                end else begin
                    case (op)
                        OP_RUN:   begin m_run = 1; m_first = 1; end
                        OP_STEP:  begin m_steps = (bus.cmd_count_i == 0) ? 1 : int'(bus.cmd_count_i); m_first = 1; end
                        OP_CLEAR: m_clr = 1;
                        OP_DUMP:  begin m_dump = 1; m_idx = 0; end
                        default:  ;
                    endcase
                end
            end
            if (bpm) begin m_run = 0; m_steps = 0; m_bp_hit = 1; end
        end
    end

    // ---------------- per-cycle compare --------------------------------
    int run_cnt, err_cnt, clr_cnt, beats;
    always @(negedge clk_i) begin
        chk("cmd_ready", bus.cmd_ready_o, m_idle() || m_run);
        chk("pc_run_en", bus.pc_run_en_o, m_run_en());
        chk("pc_clr", bus.pc_clr_o, m_clr);
        chk("cmd_err", bus.cmd_err_o, m_err);
        chk("halted", bus.halted_o, m_idle());
        chk("dump_valid", bus.dump_valid_o, m_dump);
        chk("dump_idx", bus.dump_idx_o, m_idx);
        chk("ra_debug", bus.ra_debug_o, m_idx);
        if (m_dump) chk("dump_data", bus.dump_data_o, regs[m_idx]);
        chk("cycles", bus.cycles_o, m_cycles);
        chk("core_pc", core_pc, m_pc);
`ifdef MIPS_BREAKPOINT_EN
        chk("bp_hit", bus.bp_hit_o, m_bp_hit);
`endif
        if (bus.pc_run_en_o) run_cnt++;
        if (bus.cmd_err_o)   err_cnt++;
        if (bus.pc_clr_o)    clr_cnt++;
        if (bus.dump_valid_o && bus.dump_ready_i) begin
            chk("beat_order", bus.dump_idx_o, beats % 32);
            beats++;
        end
    end

    // random sink backpressure
    always @(posedge clk_i) begin
        #1 bus.dump_ready_i = 1'($urandom % 2);
    end

    // ---------------- stimulus helpers ---------------------------------
    task automatic send(input logic [2:0] op, input int cnt);
        bit r = 0;
        int n = 0;
        bus.cmd_op_i    = op;
        bus.cmd_count_i = cnt[CNT_W-1:0];
        bus.cmd_valid_i = 1'b1;
        while (!r && n < 200) begin
            @(negedge clk_i);
            r = bus.cmd_ready_o;
            @(posedge clk_i);
            n++;
        end
        #1 bus.cmd_valid_i = 1'b0;
        if (!r) begin
            total++; bad++;
            $display("FAIL send_timeout op=%0d actual=not_accepted expected=accepted", op);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit h = 0;
        int n = 0;
        while (!h && n < budget) begin
            @(negedge clk_i);
            h = bus.halted_o;
            n++;
        end
        @(posedge clk_i);
        #1;
        if (!h) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=busy expected=halted");
        end
    endtask

    // ---------------- test sequence ------------------------------------
    initial begin
        logic [2:0] op;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_op_i     = 3'd0;
        bus.cmd_count_i  = '0;
        bus.dump_ready_i = 1'b0;
`ifdef MIPS_BREAKPOINT_EN
        bus.bp_addr_i = 32'd0;
        bus.bp_en_i   = 1'b0;
`endif
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_halted", bus.halted_o, 1);
        chk("rst_ready", bus.cmd_ready_o, 1);
        chk("rst_cycles", bus.cycles_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // 1: STEP 3 from pc 0
        run_cnt = 0;
        send(OP_STEP, 3);
        wait_idle(50);
        chk("t1_run_cycles", run_cnt, 3);
        chk("t1_pc", core_pc, 32'h0C);
        chk("t1_halted", bus.halted_o, 1);
        chk("t1_cycles", bus.cycles_o, 3);

        // 2: STEP 0 executes once; illegal op pulses error
        run_cnt = 0;
        send(OP_STEP, 0);
        wait_idle(50);
        chk("t2_step0", run_cnt, 1);
        err_cnt = 0;
        send(3'd6, 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("t2_err_pulses", err_cnt, 1);
        chk("t2_halted", bus.halted_o, 1);

        // 3: RUN, HALT after 10 cycles -> 11 executed; STEP during RUN errors
        run_cnt = 0;
        send(OP_RUN, 0);
        repeat (10) @(posedge clk_i);
        #1;
        send(OP_HALT, 0);
        wait_idle(50);
        chk("t3_run_cycles", run_cnt, 11);
        send(OP_RUN, 0);
        err_cnt = 0;
        send(OP_STEP, 2);
        send(OP_HALT, 0);
        wait_idle(50);
        chk("t3_err_in_run", err_cnt, 1);

        // 4: CLEAR
        clr_cnt = 0;
        send(OP_CLEAR, 0);
        wait_idle(50);
        chk("t4_clr_pulses", clr_cnt, 1);
        chk("t4_pc", core_pc, 0);
        chk("t4_cycles", bus.cycles_o, 0);

        // 5: DUMP with random backpressure
        beats = 0;
        send(OP_DUMP, 0);
        wait_idle(500);
        chk("t5_beats", beats, 32);

`ifdef MIPS_BREAKPOINT_EN
        // 6: breakpoint stop and resume
        bus.bp_addr_i = 32'h10;
        bus.bp_en_i   = 1'b1;
        send(OP_RUN, 0);
        wait_idle(100);
        chk("t6_bp_pc", core_pc, 32'h10);
        chk("t6_bp_hit", bus.bp_hit_o, 1);
        send(OP_RUN, 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("t6_bp_cleared", bus.bp_hit_o, 0);
        chk("t6_resumed_pc", core_pc, 32'h1C);
        send(OP_HALT, 0);
        wait_idle(50);
        bus.bp_en_i = 1'b0;
`endif

        // 7: asynchronous reset in the middle of RUN
        send(OP_RUN, 0);
        repeat (5) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("t7_rst_halted", bus.halted_o, 1);
        chk("t7_rst_run_en", bus.pc_run_en_o, 0);
        chk("t7_rst_cycles", bus.cycles_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // random command sequences
        for (int it = 0; it < 60; it++) begin
            op = 3'($urandom % 8);
            send(op, int'($urandom % 6));
            if (op == OP_RUN) begin
                repeat ($urandom % 15) @(posedge clk_i);
                #1;
                if ($urandom % 2) send(3'($urandom % 8), 1);
                send(OP_HALT, 0);
            end
            wait_idle(500);
        end

        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
